// File: rtl/midi_parser.sv
// midi_parser
//
// Purpose:
//   Assembles MIDI channel-voice messages from a stream of received bytes.
//   Each byte comes with a one-cycle strobe. A complete message is presented
//   as three parallel bytes with a one-cycle ready strobe. The parser handles
//   running status and interleaved real-time bytes. It skips SysEx and
//   system-common payloads, and abandons a half-received two-data-byte
//   message after a configurable idle time.
//
// Parameters:
//   TIMEOUT_CYCLES  IO_clk cycles without a non-real-time byte before a
//                   pending first data byte is abandoned (0 = never).
//
// Ports:
//   IO_clk           in   clock
//   IO_rst           in   synchronous active-high reset
//   IO_byte          in   received byte, valid while IO_byte_ready = 1
//   IO_byte_ready    in   one-cycle strobe per received byte
//   IO_MIDI_byte_0   out  status byte of the last emitted message
//   IO_MIDI_byte_1   out  first data byte of the last emitted message
//   IO_MIDI_byte_2   out  second data byte (0x00 for one-data-byte messages)
//   IO_MIDI_ready    out  one-cycle strobe, new message on IO_MIDI_byte_*
//   IO_MIDI_dropped  out  one-cycle strobe, data byte discarded (no status)
//
// Configuration:
//   MIDI_VEL0_NOTE_OFF_EN  when defined, an emitted Note On with velocity 0
//                          is rewritten as Note Off with velocity 0x40.

module midi_parser #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       IO_clk,
    input  logic       IO_rst,
    input  logic [7:0] IO_byte,
    input  logic       IO_byte_ready,
    output logic [7:0] IO_MIDI_byte_0,
    output logic [7:0] IO_MIDI_byte_1,
    output logic [7:0] IO_MIDI_byte_2,
    output logic       IO_MIDI_ready,
    output logic       IO_MIDI_dropped
);

    // The counter only needs to reach TIMEOUT_CYCLES, where it saturates.
    localparam int CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rs_q, rs_d;
    logic [1:0]      need_q, need_d;
    logic [7:0]      d1_q, d1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      out0_q, out0_d;
    logic [7:0]      out1_q, out1_d;
    logic [7:0]      out2_q, out2_d;
    logic            ready_q, ready_d;
    logic            dropped_q, dropped_d;

    logic            isRealTime;
    logic            isSystem;
    logic            isVoice;
    logic            isData;
    logic            timeoutHit;
    logic            emit;
    logic [7:0]      emitB0;
    logic [7:0]      emitB1;
    logic [7:0]      emitB2;

    // Byte classification, qualified by the strobe.
    assign isRealTime = IO_byte_ready && (IO_byte[7:3] == 5'b11111);
    assign isSystem   = IO_byte_ready && (IO_byte[7:3] == 5'b11110);
    assign isVoice    = IO_byte_ready && IO_byte[7] && (IO_byte[7:4] != 4'hF);
    assign isData     = IO_byte_ready && !IO_byte[7];

    // Any strobe in the same cycle, even a real-time one, takes priority
    // over the timeout.
    assign timeoutHit = TimeoutEn && (state_q == WAIT_D2) && (cnt_q == CntMax)
                        && !IO_byte_ready;

    // State register and all datapath registers.
    always_ff @(posedge IO_clk) begin
        if (IO_rst) begin
            state_q   <= IDLE;
            rs_q      <= 8'h00;
            need_q    <= 2'd2;
            d1_q      <= 8'h00;
            cnt_q     <= '0;
            out0_q    <= 8'h00;
            out1_q    <= 8'h00;
            out2_q    <= 8'h00;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rs_q      <= rs_d;
            need_q    <= need_d;
            d1_q      <= d1_d;
            cnt_q     <= cnt_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            ready_q   <= ready_d;
            dropped_q <= dropped_d;
        end
    end

    // Idle counter: cleared by any non-real-time byte and held by real-time
    // bytes. Otherwise it counts up to CntMax and stops there.
    always_comb begin
        cnt_d = cnt_q;
        if (IO_byte_ready && !isRealTime) begin
            cnt_d = '0;
        end else if (!IO_byte_ready && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Next-state and message assembly.
    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        need_d    = need_q;
        d1_d      = d1_q;
        dropped_d = 1'b0;
        emit      = 1'b0;
        emitB0    = rs_q;
        emitB1    = 8'h00;
        emitB2    = 8'h00;

        if (isVoice) begin
            // A new status always restarts assembly. Any partial message is lost.
            rs_d    = IO_byte;
            need_d  = ((IO_byte[7:4] == 4'hC) || (IO_byte[7:4] == 4'hD)) ? 2'd1 : 2'd2;
            state_d = WAIT_D1;
        end else if (isSystem) begin
            rs_d    = 8'h00;
            state_d = SKIP;
        end else if (isData) begin
            unique case (state_q)
                IDLE: begin
                    dropped_d = 1'b1;
                end
                SKIP: begin
                end
                WAIT_D1: begin
                    d1_d = IO_byte;
                    if (need_q == 2'd1) begin
                        emit   = 1'b1;
                        emitB1 = IO_byte;
                    end else begin
                        state_d = WAIT_D2;
                    end
                end
                WAIT_D2: begin
                    emit    = 1'b1;
                    emitB1  = d1_q;
                    emitB2  = IO_byte;
                    state_d = WAIT_D1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (timeoutHit) begin
            // Keep running status and wait for a fresh first data byte.
            d1_d    = 8'h00;
            state_d = WAIT_D1;
        end
    end

    // Output registers load only on an emit and otherwise hold their value.
    always_comb begin
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        ready_d = 1'b0;
        if (emit) begin
            ready_d = 1'b1;
            out0_d  = emitB0;
            out1_d  = emitB1;
            out2_d  = emitB2;
`ifdef MIDI_VEL0_NOTE_OFF_EN
            // Only the emitted copy is rewritten. Running status keeps 0x9n.
            if ((emitB0[7:4] == 4'h9) && (emitB2 == 8'h00)) begin
                out0_d = {4'h8, emitB0[3:0]};
                out2_d = 8'h40;
            end
`endif
        end
    end

    assign IO_MIDI_byte_0  = out0_q;
    assign IO_MIDI_byte_1  = out1_q;
    assign IO_MIDI_byte_2  = out2_q;
    assign IO_MIDI_ready   = ready_q;
    assign IO_MIDI_dropped = dropped_q;

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser
//
// Purpose:
//   Self-checking bench for midi_parser. The stimulus driver feeds each
//   cycle into a message-level reference model. The model pushes the
//   expected strobes, with their due time, into a queue. A separate monitor
//   pops and compares whenever the DUT raises a strobe.
//   Honours MIDI_VEL0_NOTE_OFF_EN in the same way as the design.

module tb_midi_parser;

    localparam int TO     = 16;
    localparam int PERIOD = 10;

    logic       clk;
    logic       rst;
    logic [7:0] inByte;
    logic       inReady;
    logic [7:0] midi0;
    logic [7:0] midi1;
    logic [7:0] midi2;
    logic       midiReady;
    logic       midiDropped;

    midi_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .IO_clk          (clk),
        .IO_rst          (rst),
        .IO_byte         (inByte),
        .IO_byte_ready   (inReady),
        .IO_MIDI_byte_0  (midi0),
        .IO_MIDI_byte_1  (midi1),
        .IO_MIDI_byte_2  (midi2),
        .IO_MIDI_ready   (midiReady),
        .IO_MIDI_dropped (midiDropped)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        bit         isMsg;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        time        due;
    } expect_t;

    expect_t expQ[$];

    int nChecks = 0;
    int nFails  = 0;
    bit monitorOn = 0;

    // Reference model state, kept at message level:
    // mMode: 0 = no status, 1 = collecting data for mRs, 2 = skipping payload.
    int         mMode;
    logic [7:0] mRs;
    bit         mHave;
    logic [7:0] mD1;
    int         mIdle;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue an emitted message (with the optional Note Off rewrite) or a drop.
    task automatic pushExpect(input bit isMsg, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        expect_t e;
        e.isMsg = isMsg;
        e.b0    = b0;
        e.b1    = b1;
        e.b2    = b2;
`ifdef MIDI_VEL0_NOTE_OFF_EN
        if (isMsg && b0[7:4] == 4'h9 && b2 == 8'h00) begin
            e.b0 = {4'h8, b0[3:0]};
            e.b2 = 8'h40;
        end
`endif
        e.due = $time + PERIOD;
        expQ.push_back(e);
    endtask

    task automatic modelReset();
        mMode = 0;
        mRs   = 8'h00;
        mHave = 0;
        mD1   = 8'h00;
        mIdle = 0;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] b);
        if (v) begin
            if (b >= 8'hF8) begin
                // Real-time bytes are invisible to the parser.
            end else begin
                mIdle = 0;
                if (b >= 8'hF0) begin
                    mRs   = 8'h00;
                    mMode = 2;
                    mHave = 0;
                end else if (b >= 8'h80) begin
                    mRs   = b;
                    mMode = 1;
                    mHave = 0;
                end else if (mMode == 0) begin
                    pushExpect(0, 8'h00, 8'h00, 8'h00);
                end else if (mMode == 1) begin
                    if (mRs[7:4] == 4'hC || mRs[7:4] == 4'hD) begin
                        pushExpect(1, mRs, b, 8'h00);
                    end else if (!mHave) begin
                        mHave = 1;
                        mD1   = b;
                    end else begin
                        pushExpect(1, mRs, mD1, b);
                        mHave = 0;
                    end
                end
            end
        end else begin
            if (mMode == 1 && mHave && mIdle == TO) mHave = 0;
            if (mIdle < TO) mIdle++;
        end
    endtask

    // Drive one cycle of input at the falling edge and advance the model.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r);
        @(negedge clk);
        inReady = v;
        inByte  = b;
        rst     = r;
        if (r) modelReset();
        else   modelStep(v, b);
    endtask

    task automatic sendBytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) applyStimulus(1'b1, bytes[i], 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    // Two reset cycles; the outputs must already be cleared after the first.
    task automatic applyReset(input logic v, input logic [7:0] b);
        applyStimulus(v, b, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("reset_byte0", {24'h0, midi0}, 32'h0);
        checkOutput("reset_byte1", {24'h0, midi1}, 32'h0);
        checkOutput("reset_byte2", {24'h0, midi2}, 32'h0);
        checkOutput("reset_ready", {31'h0, midiReady}, 32'h0);
        checkOutput("reset_dropped", {31'h0, midiDropped}, 32'h0);
    endtask

    // Monitor: every strobe must match the head of the queue and be on time;
    // an overdue expectation without a strobe is reported as missing.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (midiReady || midiDropped) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", {30'h0, midiReady, midiDropped}, 32'h0);
                end else begin
                    expect_t e;
                    e = expQ.pop_front();
                    checkOutput("strobe_kind", {30'h0, midiReady, midiDropped},
                                e.isMsg ? 32'h2 : 32'h1);
                    checkOutput("strobe_time", 32'($time / PERIOD), 32'(e.due / PERIOD));
                    if (e.isMsg) begin
                        checkOutput("msg_bytes", {8'h0, midi0, midi1, midi2},
                                    {8'h0, e.b0, e.b1, e.b2});
                    end
                end
            end else if (expQ.size() > 0 && expQ[0].due <= $time) begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("missing_strobe", 32'h0, e.isMsg ? 32'h2 : 32'h1);
            end
        end
    end

    initial begin
        logic [7:0] seq[$];
        int r;
        rst     = 1'b1;
        inReady = 1'b0;
        inByte  = 8'h00;
        modelReset();
        monitorOn = 1;
        applyReset(1'b0, 8'h00);

        // Single Note On.
        seq = '{8'h90, 8'h3C, 8'h64};                  sendBytes(seq); idleCycles(2);
        // Running status, with back-to-back bytes.
        seq = '{8'h91, 8'h40, 8'h7F, 8'h43, 8'h10};    sendBytes(seq); idleCycles(2);
        // One-data-byte messages.
        seq = '{8'hC2, 8'h05, 8'h07};                  sendBytes(seq); idleCycles(2);
        // Real-time interleave, then SysEx skip and a dropped byte.
        seq = '{8'h90, 8'h3C, 8'hF8, 8'h64, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h30};
        sendBytes(seq); idleCycles(2);
        // Timeout abandons the first data byte but keeps running status.
        seq = '{8'h90, 8'h3C};                         sendBytes(seq);
        idleCycles(TO + 3);
        seq = '{8'h3E, 8'h50};                         sendBytes(seq); idleCycles(2);
        // Reset mid-message: the next data byte has no status.
        seq = '{8'h90, 8'h3C};                         sendBytes(seq);
        applyReset(1'b0, 8'h00);
        seq = '{8'h64};                                sendBytes(seq); idleCycles(2);
        // Note On velocity 0.
        seq = '{8'h95, 8'h30, 8'h00};                  sendBytes(seq); idleCycles(2);
        // Reset overriding a coincident data byte.
        seq = '{8'hB1, 8'h07};                         sendBytes(seq);
        applyReset(1'b1, 8'h22);
        idleCycles(2);

        // Randomised traffic, biased towards data bytes and zero velocities.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                applyStimulus(1'b1, ($urandom_range(0, 7) == 0) ? 8'h00
                                    : 8'($urandom_range(0, 127)), 1'b0);
            end else if (r < 64) begin
                applyStimulus(1'b1, 8'($urandom_range(8'h80, 8'hEF)), 1'b0);
            end else if (r < 68) begin
                applyStimulus(1'b1, 8'($urandom_range(8'hF0, 8'hF7)), 1'b0);
            end else if (r < 75) begin
                applyStimulus(1'b1, 8'($urandom_range(8'hF8, 8'hFF)), 1'b0);
            end else if (r < 89) begin
                idleCycles(1);
            end else if (r < 98) begin
                idleCycles($urandom_range(TO - 2, TO + 3));
            end else begin
                applyReset(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end

        idleCycles(5);
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
